// File: rtl/rtc_pkg.sv
// Shared BCD constants and helpers for the real-time-clock core.
// Time is always held as 24 h packed BCD {tens, ones}.
package rtc_pkg;

    localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;

    function automatic logic bcd_valid(input logic [7:0] b, input logic [7:0] max);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
    endfunction

    // Returns {pm, hour12} for a valid 24 h BCD hour.
    function automatic logic [8:0] to_12h(input logic [7:0] hour);
        logic [6:0] bin;
        logic [6:0] h12;
        logic       pm;
        logic [7:0] bcd;
        bin = ({3'b000, hour[7:4]} * 7'd10) + {3'b000, hour[3:0]};
        pm  = (bin >= 7'd12);
        if (bin == 7'd0) begin
            h12 = 7'd12;
        end else if (bin > 7'd12) begin
            h12 = bin - 7'd12;
        end else begin
            h12 = bin;
        end
        if (h12 >= 7'd10) begin
            bcd = {4'd1, 4'(h12 - 7'd10)};
        end else begin
            bcd = {4'd0, h12[3:0]};
        end
        return {pm, bcd};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX and reports the wrap as a carry.
// Load takes priority over increment.
module bcd2_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_SEC_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_value,
    output logic       o_carry_out
);

    logic [7:0] r_value;
    logic [7:0] w_next;
    logic       w_at_max;

    assign w_at_max    = (r_value == MAX);
    assign o_carry_out = i_inc && w_at_max;
    assign o_value     = r_value;

    always_comb begin
        w_next = r_value;
        if (w_at_max) begin
            w_next = 8'h00;
        end else if (r_value[3:0] == 4'd9) begin
            w_next = {r_value[7:4] + 4'd1, 4'd0};
        end else begin
            w_next = {r_value[7:4], r_value[3:0] + 4'd1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= 8'h00;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            r_value <= w_next;
        end
    end

endmodule

// File: rtl/bcd_rtc_core.sv
// BCD real-time clock: prescaler, run/stop, validated loading, 12/24 h display
// and an HH:MM alarm. Hours, minutes and seconds are chained BCD counters.
module bcd_rtc_core
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter bit ALARM_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       alarm_hit,
    output logic       set_err
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic          r_day_tick;
    logic          r_set_err;

    logic          w_wrap;
    logic          w_inc;
    logic          w_set_ok;
    logic          w_load_ok;
    logic          w_load_bad;
    logic          w_sec_carry;
    logic          w_min_carry;
    logic          w_hour_carry;
    logic [7:0]    w_hour;
    logic [7:0]    w_min;
    logic [7:0]    w_sec;
    logic [8:0]    w_disp12;

    assign w_wrap     = run && (r_presc == PRE_MAX);
    assign w_set_ok   = bcd_valid(set_hour, BCD_HOUR_MAX) &&
                        bcd_valid(set_min, BCD_MIN_MAX) &&
                        bcd_valid(set_sec, BCD_SEC_MAX);
    assign w_load_ok  = set_valid && w_set_ok;
    assign w_load_bad = set_valid && !w_set_ok;
    // Any load, even a rejected one, swallows a coincident tick.
    assign w_inc      = w_wrap && !set_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_load_ok) begin
            r_presc <= '0;
        end else if (run && !w_load_bad) begin
            r_presc <= w_wrap ? '0 : r_presc + PW'(1);
        end
    end

    bcd2_counter #(.MAX(BCD_SEC_MAX)) u_sec (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_inc       (w_inc),
        .i_load      (w_load_ok),
        .i_load_val  (set_sec),
        .o_value     (w_sec),
        .o_carry_out (w_sec_carry)
    );

    bcd2_counter #(.MAX(BCD_MIN_MAX)) u_min (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_inc       (w_sec_carry),
        .i_load      (w_load_ok),
        .i_load_val  (set_min),
        .o_value     (w_min),
        .o_carry_out (w_min_carry)
    );

    bcd2_counter #(.MAX(BCD_HOUR_MAX)) u_hour (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_inc       (w_min_carry),
        .i_load      (w_load_ok),
        .i_load_val  (set_hour),
        .o_value     (w_hour),
        .o_carry_out (w_hour_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_sec_tick <= w_inc;
            r_day_tick <= w_hour_carry;
            r_set_err  <= w_load_bad;
        end
    end

    generate
        if (ALARM_EN) begin : g_alarm
            logic r_alarm_hit;
            // Keyed on the registered tick so a load onto the alarm time never fires.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_alarm_hit <= 1'b0;
                end else begin
                    r_alarm_hit <= r_sec_tick && alarm_en &&
                                   (w_hour == alarm_hour) &&
                                   (w_min == alarm_min) &&
                                   (w_sec == 8'h00);
                end
            end
            assign alarm_hit = r_alarm_hit;
        end else begin : g_no_alarm
            assign alarm_hit = 1'b0;
        end
    endgenerate

    assign w_disp12 = to_12h(w_hour);
    assign hour     = mode_12h ? w_disp12[7:0] : w_hour;
    assign pm       = mode_12h && w_disp12[8];
    assign min      = w_min;
    assign sec      = w_sec;
    assign sec_tick = r_sec_tick;
    assign day_tick = r_day_tick;
    assign set_err  = r_set_err;

endmodule

// File: tb/tb_bcd_rtc_core.sv
// Scenario bench for bcd_rtc_core with a 4-cycle second; expected values are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_bcd_rtc_core;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst, run, mode_12h, set_valid, alarm_en;
    logic [7:0] set_hour, set_min, set_sec, alarm_hour, alarm_min;
    logic [7:0] hour, min, sec;
    logic       pm, sec_tick, day_tick, alarm_hit, set_err;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v;
    logic [33:0] tab[6];

    wire [23:0] w_time = {hour, min, sec};

    bcd_rtc_core #(.TICKS_PER_SEC(TPS), .ALARM_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mode_12h   (mode_12h),
        .set_valid  (set_valid),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .pm         (pm),
        .sec_tick   (sec_tick),
        .day_tick   (day_tick),
        .alarm_hit  (alarm_hit),
        .set_err    (set_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [23:0] t);
        {set_hour, set_min, set_sec} = t;
        set_valid = 1'b1;
        step(1);
        set_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b1;
        set_valid = 1'b1;
        {set_hour, set_min, set_sec} = 24'h123456;
        step(2);
        set_valid = 1'b0;
        exp_q.push_back(24'h000000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (w_time !== exp_v) $display("FAIL reset_time: got %h required %h", w_time, exp_v);
        else n_pass++;
        n_checks++;
        if ({sec_tick, day_tick, alarm_hit, set_err} !== 4'b0000)
            $display("FAIL reset_pulses: got %b required 0000", {sec_tick, day_tick, alarm_hit, set_err});
        else n_pass++;
        n_checks++;
        if ({hour, pm} !== {8'h00, 1'b0}) $display("FAIL reset_24h: got %h/%b required 00/0", hour, pm);
        else n_pass++;
        mode_12h = 1'b1;
        #1;
        n_checks++;
        if ({hour, pm} !== {8'h12, 1'b0}) $display("FAIL reset_12h: got %h/%b required 12/0", hour, pm);
        else n_pass++;
        mode_12h = 1'b0;
    endtask

    task automatic test_count();
        int first = -1;
        int cnt = 0;
        int bad = 0;
        exp_q.push_back(24'h000010);
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (sec_tick) begin
                cnt++;
                if (first < 0) first = i;
                if ((i % TPS) != 0) bad++;
            end
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (w_time !== exp_v) $display("FAIL count_time: got %h required %h", w_time, exp_v);
        else n_pass++;
        n_checks++;
        if (first !== 4) $display("FAIL count_first_tick: got cycle %0d required 4", first);
        else n_pass++;
        n_checks++;
        if (cnt !== 10 || bad !== 0) $display("FAIL count_ticks: got %0d ticks %0d misplaced required 10 and 0", cnt, bad);
        else n_pass++;
    endtask

    task automatic test_rollover();
        int days = 0;
        run = 1'b0;
        drive_load(24'h235958);
        exp_q.push_back(24'h235959);
        exp_q.push_back(24'h000000);
        run = 1'b1;
        for (int i = 1; i <= 2 * TPS; i++) begin
            step(1);
            if (day_tick) days++;
            if (i == TPS) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if ({w_time, sec_tick, day_tick} !== {exp_v, 2'b10})
                    $display("FAIL roll_tick1: got %h t%b d%b required %h t1 d0", w_time, sec_tick, day_tick, exp_v);
                else n_pass++;
            end
            if (i == 2 * TPS) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if ({w_time, sec_tick, day_tick} !== {exp_v, 2'b11})
                    $display("FAIL roll_tick2: got %h t%b d%b required %h t1 d1", w_time, sec_tick, day_tick, exp_v);
                else n_pass++;
            end
        end
        n_checks++;
        if (days !== 1) $display("FAIL roll_day_count: got %0d required 1", days);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            run = 1'b0;
            drive_load((k == 0) ? 24'h095959 : 24'h195959);
            exp_q.push_back((k == 0) ? 24'h100000 : 24'h200000);
            run = 1'b1;
            step(TPS);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({w_time, sec_tick, day_tick} !== {exp_v, 2'b10})
                $display("FAIL hour_carry_%0d: got %h t%b d%b required %h t1 d0", k, w_time, sec_tick, day_tick, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_load_validation();
        int ticks = 0;
        run = 1'b0;
        drive_load(24'h010203);
        exp_q.push_back(24'h010203);
        drive_load(24'h240000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, set_err} !== {exp_v, 1'b1}) $display("FAIL load_bad_hour: got %h e%b required %h e1", w_time, set_err, exp_v);
        else n_pass++;
        step(1);
        n_checks++;
        if (set_err !== 1'b0) $display("FAIL load_err_pulse: got %b required 0", set_err);
        else n_pass++;
        exp_q.push_back(24'h010203);
        drive_load(24'h125A00);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, set_err} !== {exp_v, 1'b1}) $display("FAIL load_bad_min: got %h e%b required %h e1", w_time, set_err, exp_v);
        else n_pass++;
        run = 1'b1;
        step(2);
        exp_q.push_back(24'h123456);
        drive_load(24'h123456);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, set_err} !== {exp_v, 1'b0}) $display("FAIL load_good: got %h e%b required %h e0", w_time, set_err, exp_v);
        else n_pass++;
        for (int i = 1; i <= TPS; i++) begin
            step(1);
            if (sec_tick && i != TPS) ticks++;
        end
        exp_q.push_back(24'h123457);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, sec_tick, ticks} !== {exp_v, 1'b1, 32'd0})
            $display("FAIL load_next_tick: got %h t%b early %0d required %h t1 early 0", w_time, sec_tick, ticks, exp_v);
        else n_pass++;
    endtask

    task automatic test_collision();
        int early = 0;
        run = 1'b0;
        drive_load(24'h050000);
        run = 1'b1;
        step(TPS - 1);
        exp_q.push_back(24'h060606);
        drive_load(24'h060606);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, sec_tick} !== {exp_v, 1'b0}) $display("FAIL coll_load: got %h t%b required %h t0", w_time, sec_tick, exp_v);
        else n_pass++;
        for (int i = 1; i < TPS; i++) begin
            step(1);
            if (sec_tick) early++;
        end
        step(1);
        exp_q.push_back(24'h060607);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, sec_tick, early} !== {exp_v, 1'b1, 32'd0})
            $display("FAIL coll_presc_clear: got %h t%b early %0d required %h t1 early 0", w_time, sec_tick, early, exp_v);
        else n_pass++;
        step(TPS - 1);
        exp_q.push_back(24'h060607);
        drive_load(24'h250000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, sec_tick, set_err} !== {exp_v, 2'b01})
            $display("FAIL coll_reject: got %h t%b e%b required %h t0 e1", w_time, sec_tick, set_err, exp_v);
        else n_pass++;
        step(1);
        exp_q.push_back(24'h060608);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, sec_tick} !== {exp_v, 1'b1}) $display("FAIL coll_reject_hold: got %h t%b required %h t1", w_time, sec_tick, exp_v);
        else n_pass++;
    endtask

    task automatic test_12h();
        // {time, mode, hour, pm}
        tab = '{{24'h001500, 1'b1, 8'h12, 1'b0}, {24'h120000, 1'b1, 8'h12, 1'b1},
                {24'h235959, 1'b1, 8'h11, 1'b1}, {24'h235959, 1'b0, 8'h23, 1'b0},
                {24'h090000, 1'b1, 8'h09, 1'b0}, {24'h130000, 1'b1, 8'h01, 1'b1}};
        run = 1'b0;
        for (int r = 0; r < 6; r++) begin
            drive_load(tab[r][33:10]);
            exp_q.push_back({15'd0, tab[r][8:0]});
            mode_12h = tab[r][9];
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({hour, pm} !== exp_v[8:0] || {min, sec} !== tab[r][25:10])
                $display("FAIL disp_row%0d: got %h/%b %h%h required %h/%b %h", r, hour, pm, min, sec,
                         exp_v[8:1], exp_v[0], tab[r][25:10]);
            else n_pass++;
            mode_12h = 1'b0;
        end
    endtask

    task automatic test_alarm();
        int hits = 0;
        int hit_at = -1;
        int ticks = 0;
        alarm_hour = 8'h07;
        alarm_min = 8'h30;
        alarm_en = 1'b1;
        run = 1'b0;
        drive_load(24'h072959);
        run = 1'b1;
        for (int i = 1; i <= 2 * TPS; i++) begin
            step(1);
            if (alarm_hit) begin
                hits++;
                hit_at = i;
            end
        end
        n_checks++;
        if (hits !== 1 || hit_at !== TPS + 1) $display("FAIL alarm_fire: got %0d hits at %0d required 1 at %0d", hits, hit_at, TPS + 1);
        else n_pass++;
        hits = 0;
        run = 1'b0;
        drive_load(24'h073000);
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (alarm_hit) hits++;
        end
        n_checks++;
        if (hits !== 0) $display("FAIL alarm_on_load: got %0d hits required 0", hits);
        else n_pass++;
        alarm_en = 1'b0;
        drive_load(24'h072959);
        run = 1'b1;
        for (int i = 0; i < 2 * TPS; i++) begin
            step(1);
            if (alarm_hit) hits++;
        end
        n_checks++;
        if (hits !== 0) $display("FAIL alarm_disabled: got %0d hits required 0", hits);
        else n_pass++;
        drive_load(24'h111111);
        step(2);
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sec_tick) ticks++;
        end
        exp_q.push_back(24'h111111);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, ticks} !== {exp_v, 32'd0}) $display("FAIL run_stop: got %h ticks %0d required %h ticks 0", w_time, ticks, exp_v);
        else n_pass++;
        run = 1'b1;
        step(1);
        n_checks++;
        if (sec_tick !== 1'b0) $display("FAIL presc_hold_a: got %b required 0", sec_tick);
        else n_pass++;
        step(1);
        exp_q.push_back(24'h111112);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({w_time, sec_tick} !== {exp_v, 1'b1}) $display("FAIL presc_hold_b: got %h t%b required %h t1", w_time, sec_tick, exp_v);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        mode_12h = 1'b0;
        set_valid = 1'b0;
        set_hour = 8'h00;
        set_min = 8'h00;
        set_sec = 8'h00;
        alarm_en = 1'b0;
        alarm_hour = 8'h00;
        alarm_min = 8'h00;
        test_reset();
        test_count();
        test_rollover();
        test_load_validation();
        test_collision();
        test_12h();
        test_alarm();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_rtc_core.md
Name: bcd_rtc_core

Overview:
Parameterised BCD real-time-clock core: the next generation of the team's hexadecimal/BCD time counter. Adds a clock prescaler, run/stop control, validated time loading, runtime 12/24-hour display mode and an HH:MM alarm. It sits between the board clock and the seven-segment/display driver, which consumes packed two-digit BCD fields.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per second; must be >= 1; prescaler width is $clog2(TICKS_PER_SEC), minimum 1.
ALARM_EN, 1, 1 = alarm logic present; 0 = alarm_hit tied to 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  1 = time advances; 0 = prescaler and time frozen
mode_12h  in  1  display format: 0 = 24 h, 1 = 12 h with pm flag
set_valid  in  1  single-cycle load strobe
set_hour  in  8  load value, 24 h BCD {tens, ones}
set_min  in  8  load value, BCD
set_sec  in  8  load value, BCD
alarm_en  in  1  alarm arm
alarm_hour  in  8  alarm hour, 24 h BCD
alarm_min  in  8  alarm minute, BCD
hour  out  8  displayed hour, BCD; format per mode_12h
min  out  8  minute, BCD
sec  out  8  second, BCD
pm  out  1  1 when internal hour >= 12; forced to 0 in 24 h mode
sec_tick  out  1  1-cycle pulse on every seconds increment
day_tick  out  1  1-cycle pulse on the 23:59:59 -> 00:00:00 wrap
alarm_hit  out  1  1-cycle pulse when the alarm fires
set_err  out  1  1-cycle pulse when a load is rejected

Behaviour:
- Reset (rst = 1 at a clk edge): internal time 00:00:00; prescaler = 0; sec_tick, day_tick, alarm_hit and set_err all 0. Displayed values after reset: 24 h mode shows hour = 8'h00, pm = 0. 12 h mode shows hour = 8'h12, pm = 0. rst overrides set_valid and run.
- Internal time is always held in 24 h BCD. Every digit stays in 0–9, and field ranges are 00–23, 00–59, 00–59.
- Prescaler: when run = 1, it counts 0 .. TICKS_PER_SEC-1 and wraps. On the cycle it wraps, time increments by 1 s and sec_tick is asserted in that same cycle (registered). When run = 0, the prescaler holds its value (no reset) and no tick occurs. With TICKS_PER_SEC = 1, a tick occurs every cycle while run = 1.
- Increment and carries:
  - sec ones digit 9 -> 0 carries into sec tens; sec 59 -> 00 carries into min.
  - min 59 -> 00 carries into hour.
  - hour 09 -> 10 and 19 -> 20 are handled as BCD digit carries; hour 23 -> 00.
  - Full wrap 23:59:59 -> 00:00:00 asserts day_tick in the same cycle as sec_tick.
- Load:
  - When set_valid = 1, the load is accepted only if every nibble is <= 9, hour <= 8'h23, min <= 8'h59 and sec <= 8'h59.
  - Accepted load: time registers take the set values next cycle and the prescaler clears to 0.
  - Rejected load: time and prescaler are unchanged, and set_err pulses next cycle.
  - A load (accepted or rejected) in the same cycle as a prescaler wrap takes priority. The tick is discarded, and no sec_tick, day_tick or alarm_hit is produced.
  - Loads are accepted regardless of run.
- Display conversion is combinational from the time registers, giving zero-cycle latency on a mode_12h change:
  - 12 h mode maps internal 00 -> 12 (pm = 0), 01–11 -> unchanged (pm = 0), 12 -> 12 (pm = 1), 13–23 -> 01–11 (pm = 1).
  - min and sec are identical in both modes.
- Alarm (ALARM_EN = 1):
  - alarm_hit is registered and pulses in the cycle after a tick that makes internal time equal alarm_hour:alarm_min:00 while alarm_en = 1.
  - A load that lands exactly on the alarm time does not fire it.
  - Alarm fields are compared in 24 h form with no validation; an out-of-range alarm value never matches.
- All outputs are registered or combinational from registers only; there is no combinational path from inputs to outputs other than mode_12h.

Decomposition:
- Package rtc_pkg holds:
  - the constants BCD_SEC_MAX = 8'h59, BCD_MIN_MAX = 8'h59, BCD_HOUR_MAX = 8'h23;
  - the function bcd_valid(byte, max);
  - the function to_12h(hour) returning {pm, hour12}.
- One sub-module, bcd2_counter #(MAX): a two-digit BCD counter with inc, load, load_val and carry_out (carry is asserted when inc = 1 and the value equals MAX). It is instantiated three times (sec, min, hour) and chained via carry.
- Prescaler, load validation, alarm compare and display conversion stay in the top level.

Test Plan:
- Reset and count: TICKS_PER_SEC = 4, rst for 2 cycles, then run = 1 for 40 cycles -> sec = 8'h10; sec_tick pulses once every 4 cycles; the first pulse arrives 4 cycles after rst deasserts.
- Full rollover: load 23:59:58, run = 1 -> after 2 ticks the time is 00:00:00; day_tick is high only on the 2nd tick cycle; the 09 -> 10 hour carry is checked separately via 09:59:59 -> 10:00:00.
- Load validation: load 8'h24:00:00 and then 12:5A:00 -> each produces a set_err pulse and time is unchanged; load 12:34:56 -> time = 12:34:56, set_err stays 0, and the next tick comes exactly 4 cycles later.
- Load vs tick collision: assert set_valid on a prescaler-wrap cycle -> loaded value is held, no sec_tick, prescaler = 0.
- 12 h mode: mode_12h = 1 with internal times 00:15:00, 12:00:00 and 23:59:59 -> displayed values are 12/0, 12/1 and 11/1 (hour/pm); mode_12h = 0 with 23:59:59 -> 23/0.
- Alarm: alarm 07:30, alarm_en = 1, load 07:29:59 then one tick -> alarm_hit pulses once. Loading 07:30:00 directly -> no pulse. alarm_en = 0 -> no pulse. run = 0 -> time frozen, no ticks.
